// File: rtl/tc_operand_skew_feeder_pkg.sv
// rtl/tc_operand_skew_feeder_pkg.sv - shared types and lane helpers for the operand skew feeder
//   FSM state enum, lane index and lane depth helpers used by the feeder top.
package tc_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    GAP,
    CLEAR
  } feeder_state_e;

  // Flat lane index of element (i,j) in an n x n slice.
  function automatic int lane_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  // Skew depth of lane (i,j): one input register plus i+j wavefront stages.
  function automatic int lane_depth(input int i, input int j);
    return 1 + i + j;
  endfunction

endpackage

// File: rtl/tc_operand_skew_feeder_if.sv
// rtl/tc_operand_skew_feeder_if.sv - slice handshake and array-side bus of the operand skew feeder
//   in_valid/in_ready/in_last : slice pair handshake
//   a_in/b_in                 : un-skewed A and B slices, WIDTH*N*N bits each
//   operand_a/operand_b       : skewed wavefronts to the MAC array
//   data_valid/clc/batch_done : array result-valid tag, accumulator clear, batch end pulse
//   slice_cnt/bubble_cnt      : present only when FEEDER_PERF_CNT_EN is defined
interface tc_operand_skew_feeder_if #(
  parameter int N     = 8,
  parameter int WIDTH = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [WIDTH*N*N-1:0]     a_in;
  logic [WIDTH*N*N-1:0]     b_in;
  logic [WIDTH*N*N-1:0]     operand_a;
  logic [WIDTH*N*N-1:0]     operand_b;
  logic                     data_valid;
  logic                     clc;
  logic                     batch_done;

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]              slice_cnt;
  logic [31:0]              bubble_cnt;

  modport slave (
    input  in_valid, in_last, a_in, b_in,
    output in_ready, operand_a, operand_b, data_valid, clc, batch_done,
    output slice_cnt, bubble_cnt
  );

  modport master (
    output in_valid, in_last, a_in, b_in,
    input  in_ready, operand_a, operand_b, data_valid, clc, batch_done,
    input  slice_cnt, bubble_cnt
  );
`else
  modport slave (
    input  in_valid, in_last, a_in, b_in,
    output in_ready, operand_a, operand_b, data_valid, clc, batch_done
  );

  modport master (
    output in_valid, in_last, a_in, b_in,
    input  in_ready, operand_a, operand_b, data_valid, clc, batch_done
  );
`endif

endinterface

// File: rtl/tc_operand_skew_feeder_skew_lane.sv
// rtl/tc_operand_skew_feeder_skew_lane.sv - fixed-depth delay line carrying one operand lane plus its valid tag
//   clk, rst  : clock, asynchronous active-high reset
//   din, vin  : lane data and valid tag entering stage 0
//   dout, vout: lane data and valid tag leaving the last stage
module tc_skew_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  logic [WIDTH:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
    end else begin
      sr[0] <= {vin, din};
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  assign dout = sr[DEPTH-1][WIDTH-1:0];
  assign vout = sr[DEPTH-1][WIDTH];

endmodule

// File: rtl/tc_operand_skew_feeder.sv
// rtl/tc_operand_skew_feeder.sv - diagonally skews A/B slices (B transposed) into MAC array wavefronts
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tc_operand_skew_feeder_if slave (slice handshake in, wavefronts/data_valid/clc/batch_done out)
//   FEEDER_PERF_CNT_EN : adds bus.slice_cnt and bus.bubble_cnt saturating counters
module tc_operand_skew_feeder
  import tc_feeder_pkg::*;
#(
  parameter int N       = 8,
  parameter int WIDTH   = 8,
  parameter int CLC_GAP = 2 * N + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  tc_operand_skew_feeder_if.slave bus
);

  localparam int WN    = WIDTH * N * N;
  localparam int CNT_W = 16;

  feeder_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic             clc_q;
  logic             hs;
  logic [WN-1:0]    op_a;
  logic [WN-1:0]    op_b;
  logic [N*N-1:0]   a_tag;
  logic [N*N-1:0]   b_tag;
  logic             unused_tags;

  assign bus.in_ready = (state == IDLE) || (state == STREAM);
  assign hs           = bus.in_valid && bus.in_ready;

  // Outside a handshake every lane is fed zero data with a zero tag, which
  // covers bubbles in STREAM as well as the DRAIN flush.
  genvar gi, gj;
  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      localparam int IDX  = lane_idx(gi, gj, N);
      localparam int TIDX = lane_idx(gj, gi, N);
      localparam int DEP  = lane_depth(gi, gj);

      logic [WIDTH-1:0] a_d;
      logic [WIDTH-1:0] b_d;

      assign a_d = hs ? bus.a_in[WIDTH*IDX  +: WIDTH] : '0;
      assign b_d = hs ? bus.b_in[WIDTH*TIDX +: WIDTH] : '0;

      tc_skew_lane #(.DEPTH(DEP), .WIDTH(WIDTH)) u_lane_a (
        .clk  (clk),
        .rst  (rst),
        .din  (a_d),
        .vin  (hs),
        .dout (op_a[WIDTH*IDX +: WIDTH]),
        .vout (a_tag[IDX])
      );

      tc_skew_lane #(.DEPTH(DEP), .WIDTH(WIDTH)) u_lane_b (
        .clk  (clk),
        .rst  (rst),
        .din  (b_d),
        .vin  (hs),
        .dout (op_b[WIDTH*IDX +: WIDTH]),
        .vout (b_tag[IDX])
      );
    end
  end

  assign bus.operand_a  = op_a;
  assign bus.operand_b  = op_b;
  assign bus.data_valid = a_tag[0];

  // Only the (0,0) A tag drives data_valid; the remaining tags are redundant.
  assign unused_tags = ^{a_tag[N*N-1:1], b_tag};

  // DRAIN lasts 2N-1 cycles so lane (N-1,N-1) emits the last slice before GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      clc_q <= 1'b0;
    end else begin
      clc_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            cnt   <= '0;
            state <= bus.in_last ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (hs && bus.in_last) begin
            cnt   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt == CNT_W'(2 * N - 2)) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == CNT_W'(CLC_GAP - 1)) begin
            cnt   <= '0;
            state <= CLEAR;
            clc_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.clc        = clc_q;
  assign bus.batch_done = clc_q;

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] slice_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (state == CLEAR) begin
      slice_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (hs && (slice_cnt_q != '1)) slice_cnt_q <= slice_cnt_q + 32'd1;
      if ((state == STREAM) && !bus.in_valid && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.slice_cnt  = slice_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`else
  // Counter-free build: no performance ports on the bus.
`endif

endmodule

// File: tb/tb_tc_operand_skew_feeder.sv
// tb/tb_tc_operand_skew_feeder.sv - scoreboard bench for the operand skew feeder
module tb_tc_operand_skew_feeder;

  localparam int N       = 8;
  localparam int W       = 8;
  localparam int CLC_GAP = 2 * N + 1;
  localparam int WN      = W * N * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tc_operand_skew_feeder_if #(.N(N), .WIDTH(W)) intf ();

  tc_operand_skew_feeder #(.N(N), .WIDTH(W), .CLC_GAP(CLC_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [WN-1:0] a;
    logic [WN-1:0] b;
    bit            last;
    int            t;
  } slice_t;

  slice_t        exp_q[$];
  logic [WN-1:0] tab_a [int];
  logic [WN-1:0] tab_b [int];
  bit            tab_clc [int];

  task automatic chk(input string name, input logic [WN-1:0] act, input logic [WN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [WN-1:0] v, input int i, input int j);
    return v[W*(i*N+j) +: W];
  endfunction

  function automatic logic [WN-1:0] pat(input int seed);
    logic [WN-1:0] v;
    for (int l = 0; l < N*N; l++) v[W*l +: W] = W'(seed * 37 + l * 5 + 3);
    return v;
  endfunction

  function automatic logic [WN-1:0] idx_pat();
    logic [WN-1:0] v;
    for (int l = 0; l < N*N; l++) v[W*l +: W] = W'(l);
    return v;
  endfunction

  function automatic logic [WN-1:0] fill(input logic [W-1:0] x);
    logic [WN-1:0] v;
    for (int l = 0; l < N*N; l++) v[W*l +: W] = x;
    return v;
  endfunction

  // Monitor: pops one expected slice per data_valid and schedules its lanes
  // on the diagonal wavefront; every cycle compares the array-side outputs.
  slice_t        s;
  logic [WN-1:0] ea, eb, va, vb;
  bit            ec;

  task automatic place(input slice_t sl);
    int c;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        c  = cyc + i + j;
        va = tab_a.exists(c) ? tab_a[c] : '0;
        vb = tab_b.exists(c) ? tab_b[c] : '0;
        va[W*(i*N+j) +: W] = sl.a[W*(i*N+j) +: W];
        vb[W*(i*N+j) +: W] = sl.b[W*(j*N+i) +: W];
        tab_a[c] = va;
        tab_b[c] = vb;
      end
    end
    if (sl.last) tab_clc[cyc + (2*N-1) + CLC_GAP] = 1'b1;
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      tab_a.delete();
      tab_b.delete();
      tab_clc.delete();
    end else begin
      while (exp_q.size() > 0 && exp_q[0].t + 1 < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL dv_missing: got data_valid 0 expected 1 at cycle %0d", exp_q[0].t + 1);
        void'(exp_q.pop_front());
      end
      if (intf.data_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dv_spurious: got data_valid 1 expected 0 at cycle %0d", cyc);
        end else begin
          s = exp_q.pop_front();
          chk("dv_latency", WN'(cyc), WN'(s.t + 1));
          place(s);
        end
      end
    end
    ea = tab_a.exists(cyc) ? tab_a[cyc] : '0;
    eb = tab_b.exists(cyc) ? tab_b[cyc] : '0;
    ec = tab_clc.exists(cyc) ? tab_clc[cyc] : 1'b0;
    chk("operand_a", intf.operand_a, ea);
    chk("operand_b", intf.operand_b, eb);
    chk("clc", WN'(intf.clc), WN'(ec));
    chk("batch_done", WN'(intf.batch_done), WN'(ec));
    if (tab_a.exists(cyc)) tab_a.delete(cyc);
    if (tab_b.exists(cyc)) tab_b.delete(cyc);
    if (tab_clc.exists(cyc)) tab_clc.delete(cyc);
  end

  task automatic drive_idle();
    intf.in_valid = 1'b0;
    intf.in_last  = 1'b0;
    intf.a_in     = '0;
    intf.b_in     = '0;
  endtask

  task automatic send(input logic [WN-1:0] a, input logic [WN-1:0] b, input bit last,
                      output int t, output int blocked);
    blocked = 0;
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      intf.in_valid = 1'b1;
      intf.in_last  = last;
      intf.a_in     = a;
      intf.b_in     = b;
      if (intf.in_ready) begin
        t = cyc;
        exp_q.push_back('{a, b, last, cyc});
        break;
      end
      blocked++;
    end
    if (t < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 200 cycles expected 1");
    end
  endtask

  task automatic idle_until(input int c);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      drive_idle();
      if (cyc >= c) break;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  int t0, t1, t2, bl, got;

  initial begin
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("reset_in_ready", WN'(intf.in_ready), WN'(1));
    chk("reset_data_valid", WN'(intf.data_valid), WN'(0));
    chk("reset_clc", WN'(intf.clc), WN'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single-slice batch with index patterns.
    send(idx_pat(), idx_pat(), 1'b1, t0, bl);
    idle_until(t0 + 9);
    #2;
    chk("lane35_a", WN'(lane(intf.operand_a, 3, 5)), WN'(29));
    chk("lane35_b", WN'(lane(intf.operand_b, 3, 5)), WN'(43));
    got = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      drive_idle();
      #2;
      if (intf.clc) begin
        got = cyc;
        break;
      end
    end
    chk("clc_cycle", WN'(got), WN'(t0 + 33));
    idle(3);

    // Sign extremes.
    send(fill(8'h80), fill(8'h7F), 1'b1, t0, bl);
    idle_until(t0 + 1);
    #2;
    chk("sign_a00", WN'(lane(intf.operand_a, 0, 0)), WN'(8'h80));
    chk("sign_b00", WN'(lane(intf.operand_b, 0, 0)), WN'(8'h7F));
    idle_until(t0 + 15);
    #2;
    chk("sign_a77", WN'(lane(intf.operand_a, 7, 7)), WN'(8'h80));
    chk("sign_b77", WN'(lane(intf.operand_b, 7, 7)), WN'(8'h7F));
    idle(40);

    // Bubble, with a stray in_last while in_valid is low.
    send(pat(1), pat(2), 1'b0, t0, bl);
    @(negedge clk);
    intf.in_valid = 1'b0;
    intf.in_last  = 1'b1;
    send(pat(3), pat(4), 1'b1, t2, bl);
    chk("bubble_accept", WN'(t2), WN'(t0 + 2));
    idle_until(t0 + 16);
    #2;
    chk("bubble_a77", WN'(lane(intf.operand_a, 7, 7)), WN'(0));
    idle_until(t0 + 17);
    #2;
    chk("bubble2_a77", WN'(lane(intf.operand_a, 7, 7)), WN'(lane(pat(3), 7, 7)));
    idle(40);

    // Backpressure across DRAIN/GAP/CLEAR.
    send(pat(5), pat(6), 1'b0, t0, bl);
    send(pat(7), pat(8), 1'b0, t1, bl);
    send(pat(9), pat(10), 1'b1, t2, bl);
    send(pat(11), pat(12), 1'b1, t0, bl);
    chk("bp_blocked", WN'(bl), WN'(33));
    chk("bp_accept", WN'(t0), WN'(t2 + 34));
    idle(45);

    // Reset in the middle of STREAM.
    for (int k = 0; k < 10; k++) send(pat(20 + k), pat(40 + k), 1'b0, t0, bl);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #2;
    chk("rst_data_valid", WN'(intf.data_valid), WN'(0));
    chk("rst_operand_a", intf.operand_a, '0);
    chk("rst_operand_b", intf.operand_b, '0);
    chk("rst_in_ready", WN'(intf.in_ready), WN'(1));
    @(negedge clk);
    rst = 1'b0;
    idle(50);

    // K=32 back-to-back batch.
    for (int k = 0; k < 32; k++) begin
      send(pat(100 + k), pat(200 + k), (k == 31), t0, bl);
      chk("k32_no_stall", WN'(bl), WN'(0));
    end
    idle(45);

    chk("queue_empty", WN'(exp_q.size()), WN'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000ns");
    $fatal(1);
  end

endmodule

// File: doc/tc_operand_skew_feeder.md
Name: tc_operand_skew_feeder

Overview:
- Upstream feeder for the N x N MAC tensor-core array (`top`).
- Accepts one un-skewed A slice and one un-skewed B slice (NxN each, z-th sub-matrix of a K-deep batch) per handshake.
- Produces the diagonally skewed, B-transposed operand_a/operand_b wavefronts the array consumes, plus data_valid for the array's result-valid pipeline.
- After the last slice it flushes the skew pipeline, then pulses clc to clear array accumulators before the next batch.

Parameters:
- N, 8, array dimension; the array's reduction dimension must match.
- WIDTH, 8, signed operand width.
- CLC_GAP, 2*N+1, idle cycles after drain before the clc pulse; covers the array result drain.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  slice pair valid
- in_ready  output  1  feeder accepts a slice this cycle
- in_last  input  1  marks final slice of batch (sampled with handshake)
- a_in  input  WIDTH*N*N  A slice; element [i][j] at bits WIDTH*(i*N+j)
- b_in  input  WIDTH*N*N  B slice; element [k][j] at bits WIDTH*(k*N+j)
- operand_a  output  WIDTH*N*N  to array A
- operand_b  output  WIDTH*N*N  to array B
- data_valid  output  1  lane (0,0) carries a real slice this cycle
- clc  output  1  one-cycle accumulator clear
- batch_done  output  1  one-cycle pulse, coincident with clc

Behaviour:
- Reset state:
  - All lane registers, valid tags, counters and outputs are 0.
  - FSM is in IDLE.
  - Reset asserted mid-batch discards all in-flight slices immediately.
- Skew pipeline:
  - Lane (i,j) is a shift register of depth 1+i+j.
  - Every stage advances every cycle; the array has no stall.
  - A slice accepted at cycle t drives operand_a lane (i,j) = a_in[i][j] at cycle t+1+i+j.
  - It drives operand_b lane (i,j) = b_in[j][i] at cycle t+1+i+j (transpose).
  - A lane outputs 0 in any cycle it carries no accepted slice.
- Bubble rule:
  - In STREAM with in_valid=0, an all-zero slice with valid tag 0 enters the pipeline.
  - data_valid = valid tag at lane (0,0), i.e. 1 exactly one cycle after each accepted slice.
- FSM:
  - IDLE: in_ready=1. A handshake moves to STREAM, or directly to DRAIN if in_last=1.
  - STREAM: in_ready=1. A handshake with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. Zero slices enter for 2N-1 cycles (counter 0..2N-2), until lane (N-1,N-1) has emitted the last slice. Then moves to GAP.
  - GAP: in_ready=0. Holds for CLC_GAP cycles, then moves to CLEAR.
  - CLEAR: clc=1 and batch_done=1 for exactly one cycle, then moves to IDLE.
- Handshake: transfer occurs when in_valid && in_ready. in_last without in_valid is ignored.
- Arithmetic: no arithmetic on operands; values pass bit-exact, sign preserved.
- Register budget: N*N*N lane registers per operand (sum of (1+i+j) over i,j).

Optional Feature:
- Macro: FEEDER_PERF_CNT_EN.
- Defined: adds outputs slice_cnt[31:0] (accepted slices this batch) and bubble_cnt[31:0] (STREAM cycles with in_valid=0).
  - Both counters are cleared on rst and in CLEAR.
  - Both saturate at all-ones.
- Undefined: neither port exists and no counter logic is present.

Decomposition:
- Package tc_feeder_pkg:
  - FSM state enum {IDLE, STREAM, DRAIN, GAP, CLEAR}.
  - Function lane_idx(i,j) = i*N+j.
  - Function lane_depth(i,j) = 1+i+j.
- Sub-module tc_skew_lane: parameterised-depth WIDTH+1-bit delay line (data plus valid tag) with async reset.
  - Instantiated N*N times per operand in a generate loop.
  - The B lanes' valid bits are left unused.

Test Plan:
- Single-slice batch, a[i][j]=i*8+j, b[k][j]=k*8+j, in_last=1, accepted at t0 -> data_valid=1 only at t0+1.
  - operand_a lane (3,5) = 29 only at t0+9.
  - operand_b lane (3,5) = b[5][3] = 43 at t0+9.
  - clc/batch_done pulse at t0+1+15+17.
- K=32 random batch, back-to-back in_valid -> data_valid high for 32 consecutive cycles.
  - Connected to `top` with the result-collection checker, all 32 C slices match the golden model.
- Bubble: valid slices at t0, t0+2, with in_valid=0 at t0+1 -> data_valid pattern 1,0,1.
  - Lane (7,7) is 0 at t0+16.
- Backpressure: in_valid held high through DRAIN/GAP -> in_ready=0.
  - No second-batch data enters until the cycle after CLEAR.
  - First lane of the new batch appears after clc.
- Reset mid-STREAM after 10 slices -> the cycle after rst asserts, all operand lanes and data_valid are 0 and in_ready=1 (IDLE).
  - No clc pulse is produced for the aborted batch.
- Sign extremes: a=-128 / b=127 in all lanes -> every lane emits 8'h80 and 8'h7F respectively at its skewed cycle.
